// File: rtl/prach_tdm_mux.sv
// rtl/prach_tdm_mux.sv - round-robin TDM multiplexer of per-channel I/Q streams
module prach_tdm_mux #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] din_dr,
  input  logic [NUM_CH*DW-1:0] din_di,
  input  logic [NUM_CH-1:0]    din_dv,
  input  logic                 sync_in,
  input  logic [NUM_CH-1:0]    ctrl_ch_en,
  input  logic                 ovf_clr,
  output logic [DW-1:0]        dout_dr,
  output logic [DW-1:0]        dout_di,
  output logic                 dout_dv,
  output logic [7:0]           dout_chn,
  output logic                 sync_out,
  output logic [NUM_CH-1:0]    err_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = 2 * DW;

  // slot counter and FIFO state
  logic [7:0]        s_q, s_d;
  logic [WW-1:0]     mem_q    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [NUM_CH];
  logic [AW-1:0]     wr_ptr_d [NUM_CH];
  logic [AW-1:0]     rd_ptr_q [NUM_CH];
  logic [AW-1:0]     rd_ptr_d [NUM_CH];
  logic [CW-1:0]     cnt_q    [NUM_CH];
  logic [CW-1:0]     cnt_d    [NUM_CH];

  // per-cycle decisions
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] ovf_set;
  logic [WW-1:0]     head;

  // registered outputs
  logic [DW-1:0]     dout_dr_q;
  logic [DW-1:0]     dout_di_q;
  logic              dout_dv_q;
  logic [7:0]        dout_chn_q;
  logic              sync_d1_q;
  logic              sync_out_q;
  logic [NUM_CH-1:0] err_ovf_q;

  // next slot: wrap at the frame end, or restart at 0 after a sync pulse
  always_comb begin
    s_d = s_q + 8'd1;
    if (sync_in || s_q == 8'(NUM_CH - 1)) begin
      s_d = 8'd0;
    end
  end

  // pop the current slot's FIFO; a full FIFO still accepts a push when it is popped this cycle
  always_comb begin
    pop     = '0;
    push    = '0;
    ovf_set = '0;
    head    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s_q == 8'(k) && ctrl_ch_en[k] && cnt_q[k] != '0) begin
        pop[k] = 1'b1;
        head   = mem_q[k][rd_ptr_q[k]];
      end
      if (din_dv[k] && ctrl_ch_en[k]) begin
        if (cnt_q[k] != CW'(FIFO_DEPTH) || pop[k]) begin
          push[k] = 1'b1;
        end else begin
          ovf_set[k] = 1'b1;
        end
      end
    end
  end

  // pointer and occupancy update; a disabled channel is flushed to empty
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k];
      if (!ctrl_ch_en[k]) begin
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
        cnt_d[k]    = '0;
      end else begin
        if (push[k]) begin
          wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
        end
        if (pop[k]) begin
          rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
          2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
          default: cnt_d[k] = cnt_q[k];
        endcase
      end
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 8'd0;
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      s_q <= s_d;
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  end

  // sample storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= {din_dr[k*DW +: DW], din_di[k*DW +: DW]};
      end
    end
  end

  // output beat, two-stage sync delay and sticky overflow flags (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_dr_q  <= '0;
      dout_di_q  <= '0;
      dout_dv_q  <= 1'b0;
      dout_chn_q <= 8'd0;
      sync_d1_q  <= 1'b0;
      sync_out_q <= 1'b0;
      err_ovf_q  <= '0;
    end else begin
      dout_dr_q  <= head[WW-1:DW];
      dout_di_q  <= head[DW-1:0];
      dout_dv_q  <= |pop;
      dout_chn_q <= s_q;
      sync_d1_q  <= sync_in;
      sync_out_q <= sync_d1_q;
      err_ovf_q  <= (ovf_clr ? '0 : err_ovf_q) | ovf_set;
    end
  end

  assign dout_dr  = dout_dr_q;
  assign dout_di  = dout_di_q;
  assign dout_dv  = dout_dv_q;
  assign dout_chn = dout_chn_q;
  assign sync_out = sync_out_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_prach_tdm_mux.sv
// tb/tb_prach_tdm_mux.sv - randomized and directed bench for prach_tdm_mux against a queue model
module tb_prach_tdm_mux;

  localparam int NUM_CH     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = 16;

  logic                 clk;
  logic                 rst;
  logic [NUM_CH*DW-1:0] din_dr;
  logic [NUM_CH*DW-1:0] din_di;
  logic [NUM_CH-1:0]    din_dv;
  logic                 sync_in;
  logic [NUM_CH-1:0]    ctrl_ch_en;
  logic                 ovf_clr;
  logic [DW-1:0]        dout_dr;
  logic [DW-1:0]        dout_di;
  logic                 dout_dv;
  logic [7:0]           dout_chn;
  logic                 sync_out;
  logic [NUM_CH-1:0]    err_ovf;

  prach_tdm_mux #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_dr     (din_dr),
    .din_di     (din_di),
    .din_dv     (din_dv),
    .sync_in    (sync_in),
    .ctrl_ch_en (ctrl_ch_en),
    .ovf_clr    (ovf_clr),
    .dout_dr    (dout_dr),
    .dout_di    (dout_di),
    .dout_dv    (dout_dv),
    .dout_chn   (dout_chn),
    .sync_out   (sync_out),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;

  // reference model: one queue per channel, plain slot index
  logic [2*DW-1:0] mq [NUM_CH][$];
  int              ms;
  logic            sync_p;
  logic            e_dv;
  logic [DW-1:0]   e_dr;
  logic [DW-1:0]   e_di;
  logic [7:0]      e_chn;
  logic            e_sync;
  logic [NUM_CH-1:0] e_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] i_v, input logic [DW-1:0] q_v);
    din_dv[k] = 1'b1;
    din_dr[k*DW +: DW] = i_v;
    din_di[k*DW +: DW] = q_v;
  endtask

  // advance the model on the current inputs, clock the DUT, compare every output
  task automatic step();
    logic [NUM_CH-1:0] set_v;
    logic [2*DW-1:0]   w;
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) mq[k].delete();
      ms = 0; sync_p = 1'b0;
      e_dv = 1'b0; e_dr = '0; e_di = '0; e_chn = '0; e_sync = 1'b0; e_ovf = '0;
    end else begin
      e_chn = 8'(ms);
      if (ctrl_ch_en[ms] && mq[ms].size() > 0) begin
        w = mq[ms].pop_front();
        e_dv = 1'b1; e_dr = w[2*DW-1:DW]; e_di = w[DW-1:0];
      end else begin
        e_dv = 1'b0; e_dr = '0; e_di = '0;
      end
      set_v = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ctrl_ch_en[k]) mq[k].delete();
        else if (din_dv[k]) begin
          if (mq[k].size() < FIFO_DEPTH) mq[k].push_back({din_dr[k*DW +: DW], din_di[k*DW +: DW]});
          else set_v[k] = 1'b1;
        end
      end
      e_sync = sync_p;
      sync_p = sync_in;
      e_ovf  = (ovf_clr ? '0 : e_ovf) | set_v;
      ms     = sync_in ? 0 : (ms + 1) % NUM_CH;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("dout_dv", dout_dv, e_dv);
    chk("dout_chn", dout_chn, e_chn);
    chk("dout_dr", dout_dr, e_dr);
    chk("dout_di", dout_di, e_di);
    chk("sync_out", sync_out, e_sync);
    chk("err_ovf", err_ovf, e_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int nx;
    int gaps;
    int cnt;
    logic [DW-1:0] got5 [$];

    total = 0; bad = 0; cyc = 0;
    ms = 0; sync_p = 1'b0; e_ovf = '0;
    rst = 1'b1; din_dr = '0; din_di = '0; din_dv = '0;
    sync_in = 1'b0; ctrl_ch_en = '1; ovf_clr = 1'b0;

    // reset state
    idle(3);
    chk("rst_dv", dout_dv, 1'b0);
    chk("rst_ovf", err_ovf, '0);
    rst = 1'b0;

    // sync at cycle 10 -> sync_out two cycles later on slot 0
    while (cyc < 10) step();
    sync_in = 1'b1; step(); sync_in = 1'b0;
    step();
    chk("t1_sync", sync_out, 1'b1);
    chk("t1_chn", dout_chn, 8'd0);
    chk("t1_dv", dout_dv, 1'b0);
    idle(16);

    // single sample on channel 3 when s=2 -> out two cycles later
    while (ms != 2) step();
    set_ch(3, 16'h1234, 16'hABCD); step(); din_dv = '0;
    step();
    chk("t2_dv", dout_dv, 1'b1);
    chk("t2_chn", dout_chn, 8'd3);
    chk("t2_dr", dout_dr, 16'h1234);
    chk("t2_di", dout_di, 16'hABCD);
    idle(8);

    // overflow burst on channel 5
    while (ms != 6) step();
    for (int i = 1; i <= 6; i++) begin
      din_dv = '0; set_ch(5, 16'(i), 16'(i + 256)); step();
    end
    din_dv = '0;
    chk("t3_ovf_set", err_ovf[5], 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (dout_dv && dout_chn == 8'd5) got5.push_back(dout_dr);
    end
    chk("t3_count", got5.size(), 4);
    for (int i = 0; i < got5.size() && i < 4; i++) chk("t3_order", got5[i], i + 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", err_ovf[5], 1'b0);

    // full-rate: each channel fed one cycle before its slot
    gaps = 0;
    for (int f = 0; f < 1000 * NUM_CH; f++) begin
      nx = (ms + 1) % NUM_CH;
      din_dv = '0; set_ch(nx, 16'($urandom), 16'($urandom));
      step();
      if (f >= 2 && dout_dv !== 1'b1) gaps++;
    end
    din_dv = '0;
    chk("t4_gaps", gaps, 0);
    chk("t4_ovf", err_ovf, '0);
    idle(4);

    // random traffic with syncs, enables, clears and resets
    for (int i = 0; i < 3000; i++) begin
      din_dv  = NUM_CH'($urandom);
      din_dr  = {$urandom, $urandom, $urandom, $urandom};
      din_di  = {$urandom, $urandom, $urandom, $urandom};
      sync_in = ($urandom_range(0, 39) == 0);
      ovf_clr = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) ctrl_ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      step();
    end
    rst = 1'b0; din_dv = '0; sync_in = 1'b0; ovf_clr = 1'b0; ctrl_ch_en = '1;
    idle(40);

    // mid-frame sync keeps buffered samples
    while (ms != 1) step();
    set_ch(6, 16'h6666, 16'h0666); step(); din_dv = '0;
    while (ms != 4) step();
    sync_in = 1'b1; step(); sync_in = 1'b0;
    step();
    chk("t5_sync", sync_out, 1'b1);
    chk("t5_chn", dout_chn, 8'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dout_dv && dout_chn == 8'd6 && dout_dr == 16'h6666) cnt++;
    end
    chk("t5_kept", cnt, 1);

    // channel disable flushes buffered samples
    while (ms != 3) step();
    for (int i = 0; i < 3; i++) begin
      din_dv = '0; set_ch(2, 16'h2200 + 16'(i), 16'h0022); step();
    end
    din_dv = '0;
    ctrl_ch_en[2] = 1'b0; step(); ctrl_ch_en[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (dout_dv && dout_chn == 8'd2) cnt++;
    end
    chk("t6_flushed", cnt, 0);
    set_ch(2, 16'h2BBB, 16'h0BBB); step(); din_dv = '0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dout_dv && dout_chn == 8'd2 && dout_dr == 16'h2BBB) cnt++;
    end
    chk("t6_new", cnt, 1);

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      din_dv = '1; din_dr = {$urandom, $urandom, $urandom, $urandom}; step();
    end
    rst = 1'b1; step();
    chk("t7_dv", dout_dv, 1'b0);
    chk("t7_dr", dout_dr, '0);
    chk("t7_chn", dout_chn, 8'd0);
    chk("t7_ovf", err_ovf, '0);
    rst = 1'b0; din_dv = '0;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prach_tdm_mux.md
Name: prach_tdm_mux

Overview:
- Builds the channel-interleaved TDM stream consumed by the PRACH mixer/NCO chain: sample, valid, channel index and sync.
- Accepts NUM_CH independent per-channel I/Q sample streams.
- Buffers each stream in a small per-channel FIFO.
- Emits one channel slot per clock in fixed round-robin order, aligned to sync_in.

Parameters:
- NUM_CH, 8, number of channels/slots per TDM frame (2..256).
- FIFO_DEPTH, 4, per-channel FIFO depth in samples (power of two, >=2).
- DW, 16, I and Q sample width.

Ports:
- clk  in  1  processing clock
- rst  in  1  synchronous active-high reset
- din_dr  in  NUM_CH*DW  per-channel I; channel k at bits [k*DW +: DW]
- din_di  in  NUM_CH*DW  per-channel Q, same packing
- din_dv  in  NUM_CH  per-channel sample valid
- sync_in  in  1  frame sync pulse
- ctrl_ch_en  in  NUM_CH  channel enable, quasi-static
- ovf_clr  in  1  clears sticky overflow flags
- dout_dr  out  DW  TDM I
- dout_di  out  DW  TDM Q
- dout_dv  out  1  slot carries a valid sample
- dout_chn  out  8  slot channel index
- sync_out  out  1  marks slot 0 of a frame following sync_in
- err_ovf  out  NUM_CH  sticky per-channel overflow flags

Behaviour:
- Reset (rst=1 at an edge): slot counter=0, all FIFOs empty, all outputs 0 (dout_*, sync_out, err_ovf). Reset mid-stream discards buffered samples.
- Slot counter s: increments every cycle, wraps NUM_CH-1 -> 0.
- sync_in=1 in cycle c: s=0 in cycle c+1, regardless of its prior value.
- Pop: in cycle c, if FIFO[s] is non-empty, it is popped.
- Outputs: registered. The cycle-c decision appears in cycle c+1:
  - dout_chn=s always.
  - On pop: dout_dv=1, dout_dr/di=FIFO head.
  - Otherwise: dout_dv=0, dout_dr/di=0.
- sync_out=1 in cycle c+2 for sync_in in cycle c. It coincides with the slot-0 output beat and is independent of dout_dv.
- Push: din_dv[k]=1 and ctrl_ch_en[k]=1 at an edge writes the sample into FIFO[k].
  - A word written at an edge is not poppable in the same cycle. There is no bypass.
  - Latency from input cycle to output cycle: min 2, max NUM_CH+1.
- Full FIFO:
  - Push is accepted if count<FIFO_DEPTH, or if FIFO[k] is popped in the same cycle.
  - Otherwise the sample is dropped and err_ovf[k] is set the next cycle.
  - FIFO order is preserved; count never exceeds FIFO_DEPTH.
- Empty FIFO with push in the same cycle: no pop; the slot is output with dout_dv=0.
- ctrl_ch_en[k]=0: pushes to channel k are ignored and FIFO[k] is flushed to empty on the next edge. Slot k still appears, with dout_dv=0.
- err_ovf:
  - Sticky.
  - ovf_clr=1 clears all flags next cycle.
  - Simultaneous set and clear: set wins.
- Per-channel FIFO pointers wrap modulo FIFO_DEPTH. count uses log2(FIFO_DEPTH)+1 bits.
- Data passes through unmodified; no arithmetic is applied.

Test Plan:
- Reset, then sync_in pulse at cycle 10, no input valid -> sync_out=1 at cycle 12 with dout_chn=0, dout_dv=0. dout_chn then sequences 0..7 repeating; err_ovf=0.
- Channel 3 gets sample (I=0x1234, Q=0xABCD) in the cycle where s=2 -> dout_dv=1, dout_chn=3, dout_dr=0x1234, dout_di=0xABCD, exactly 2 cycles later. All other slots have dout_dv=0.
- Channel 5 gets 6 consecutive samples 1..6 within one frame, FIFO_DEPTH=4, with slot 5 not visited during the burst -> samples 1..4 emitted in order on successive slot-5 beats. 5 and 6 are dropped; err_ovf[5]=1. ovf_clr pulse -> err_ovf[5]=0.
- All 8 channels valid every 8th cycle, each input aligned one cycle before its slot -> every output beat has dout_dv=1 with correct channel data. No overflow over 1000 frames.
- Mid-frame sync_in at s=4 -> next cycle s=0. Output sequence resumes at chn 0 with sync_out. Buffered samples are retained and emitted in their channel slots.
- ctrl_ch_en[2] cleared while FIFO[2] holds 3 samples, then set again -> no further dv on chn 2 until new input arrives. Old samples are never emitted. rst asserted mid-burst -> all outputs 0 the next cycle.
